vga_timing_gen: RTL and testbench

Parametrised VGA raster timing generator for the TinyTapeout VGA top level. It produces horizontal and vertical sync, a display-active flag, pixel coordinates, line and frame strobes, and a wrapping frame counter. Pixel rate is derived from `clk` through an integer clock-enable divider. It replaces the fixed 640x480 sync logic so that other resolutions, sync polarities and pixel-clock ratios come from parameters alone.

---
 rtl/vga_timing_pkg.sv | 28 ++
 rtl/vga_axis_counter.sv | 60 ++++++
 rtl/vga_timing_gen.sv | 116 +++++++++++
 tb/tb_vga_timing_gen.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, polarity names and the line/frame length helper.
package vga_timing_pkg;

    // Sync polarity names, shared with the top level and the pattern generators
    localparam bit SYNC_ACTIVE_LOW  = 1'b0;
    localparam bit SYNC_ACTIVE_HIGH = 1'b1;

    // 640x480@60 defaults
    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;
    localparam bit          VGA_HSYNC_POL = SYNC_ACTIVE_LOW;
    localparam bit          VGA_VSYNC_POL = SYNC_ACTIVE_LOW;

    // Total period of one axis (pixels per line or lines per frame)
    function automatic int unsigned vga_total(input int unsigned active,
                                              input int unsigned fp,
                                              input int unsigned sync,
                                              input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with registered sync decode.
// wrap and active describe the next state (combinational); pos and sync are registered.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned FP     = VGA_H_FP,
    parameter int unsigned SYNC   = VGA_H_SYNC,
    parameter int unsigned BP     = VGA_H_BP,
    parameter bit          POL    = SYNC_ACTIVE_LOW,
    localparam int unsigned TOTAL = vga_total(ACTIVE, FP, SYNC, BP),
    localparam int unsigned W     = $clog2(TOTAL)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         step,
    output logic [W-1:0] pos,
    output logic         wrap,
    output logic         sync,
    output logic         active
);

    localparam int unsigned SYNC_LO = ACTIVE + FP;
    localparam int unsigned SYNC_HI = SYNC_LO + SYNC;

    logic [W-1:0] pos_nxt;
    logic         in_sync;

    // Next position: advance on step, wrap after the last position
    always_comb begin
        pos_nxt = pos;
        wrap    = 1'b0;
        if (step) begin
            if (pos == W'(TOTAL - 1)) begin
                pos_nxt = '0;
                wrap    = 1'b1;
            end else begin
                pos_nxt = pos + W'(1);
            end
        end
    end

    // Decode from the next position so the registered flags line up with pos
    always_comb begin
        in_sync = (32'(pos_nxt) >= SYNC_LO) && (32'(pos_nxt) < SYNC_HI);
        active  = 32'(pos_nxt) < ACTIVE;
    end

    // Position and sync registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos  <= '0;
            sync <= ~POL;
        end else begin
            pos  <= pos_nxt;
            sync <= in_sync ? POL : ~POL;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with integer pixel-clock divider.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = VGA_H_ACTIVE,
    parameter int unsigned H_FP      = VGA_H_FP,
    parameter int unsigned H_SYNC    = VGA_H_SYNC,
    parameter int unsigned H_BP      = VGA_H_BP,
    parameter int unsigned V_ACTIVE  = VGA_V_ACTIVE,
    parameter int unsigned V_FP      = VGA_V_FP,
    parameter int unsigned V_SYNC    = VGA_V_SYNC,
    parameter int unsigned V_BP      = VGA_V_BP,
    parameter bit          HSYNC_POL = VGA_HSYNC_POL,
    parameter bit          VSYNC_POL = VGA_VSYNC_POL,
    parameter int unsigned PIX_DIV   = 1,
    parameter int unsigned FRAME_W   = 8,
    localparam int unsigned H_TOTAL  = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
    localparam int unsigned V_TOTAL  = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
    localparam int unsigned HW       = $clog2(H_TOTAL),
    localparam int unsigned VW       = $clog2(V_TOTAL)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    output logic               pix_en,
    output logic [HW-1:0]      hpos,
    output logic [VW-1:0]      vpos,
    output logic               hsync,
    output logic               vsync,
    output logic               display_on,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_cnt
);

    localparam int unsigned DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    // Zero-width sync pulses and a zero divider have no meaningful raster
    generate
        if (H_SYNC == 0 || V_SYNC == 0 || PIX_DIV == 0) begin : g_illegal_params
            $error("vga_timing_gen: H_SYNC, V_SYNC and PIX_DIV must be non-zero");
        end
    endgenerate

    logic [DW-1:0] div;
    logic          div_last;
    logic          h_wrap;
    logic          v_wrap;
    logic          h_active;
    logic          v_active;

    // Pixel strobe; gated by rst_n so it reads 0 while reset is held
    always_comb begin
        div_last = (div == DW'(PIX_DIV - 1));
        pix_en   = rst_n & ena & div_last;
    end

    // clk-to-pixel divider, frozen while ena is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div <= '0;
        end else if (ena) begin
            div <= div_last ? '0 : div + DW'(1);
        end
    end

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .POL    (HSYNC_POL)
    ) u_h_axis (
        .clk    (clk),
        .rst_n  (rst_n),
        .step   (pix_en),
        .pos    (hpos),
        .wrap   (h_wrap),
        .sync   (hsync),
        .active (h_active)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .POL    (VSYNC_POL)
    ) u_v_axis (
        .clk    (clk),
        .rst_n  (rst_n),
        .step   (h_wrap),
        .pos    (vpos),
        .wrap   (v_wrap),
        .sync   (vsync),
        .active (v_active)
    );

    // Display flag, line/frame strobes and completed-frame counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            display_on  <= 1'b1;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            display_on  <= h_active & v_active;
            line_start  <= h_wrap;
            frame_start <= v_wrap;
            if (v_wrap) begin
                frame_cnt <= frame_cnt + FRAME_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: small divided raster (active-high syncs) plus default 640x480.
module tb_vga_timing_gen;

    typedef struct {
        int cyc; int ep;
        int h; int v; int hs; int vs; int d; int ls; int fs; int fc; int pe;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic ena;
    logic dena;

    // Small raster: H 4/1/2/1 (8), V 3/1/1/1 (6), PIX_DIV=3, active-high syncs
    logic       s_pix_en, s_hsync, s_vsync, s_disp, s_ls, s_fs;
    logic [2:0] s_hpos, s_vpos, s_fc;
    // Default 640x480 raster, PIX_DIV=1
    logic       d_pix_en, d_hsync, d_vsync, d_disp, d_ls, d_fs;
    logic [9:0] d_hpos, d_vpos;
    logic [7:0] d_fc;

    int checks = 0;
    int errors = 0;
    int act, dact;
    int epoch = 0;
    int ls_n = 0, fs_n = 0, pe_n = 0, hs_low_n = 0, disp_low_n = 0;
    exp_t q_s[$];
    exp_t q_d[$];
    exp_t es, gs, ed, gd;

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .PIX_DIV(3), .FRAME_W(3)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .pix_en(s_pix_en),
        .hpos(s_hpos), .vpos(s_vpos), .hsync(s_hsync), .vsync(s_vsync),
        .display_on(s_disp), .line_start(s_ls), .frame_start(s_fs), .frame_cnt(s_fc)
    );

    vga_timing_gen u_def (
        .clk(clk), .rst_n(rst_n), .ena(dena), .pix_en(d_pix_en),
        .hpos(d_hpos), .vpos(d_vpos), .hsync(d_hsync), .vsync(d_vsync),
        .display_on(d_disp), .line_start(d_ls), .frame_start(d_fs), .frame_cnt(d_fc)
    );

    always #5 clk = ~clk;

    // Bench-side clocks: enabled edges for the small DUT, all edges for the default one
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) act <= 0;
        else if (ena) act <= act + 1;
    end
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) dact <= 0;
        else dact <= dact + 1;
    end

    function automatic exp_t mk(input int cyc, input int ep, input int h, input int v,
                                input int hs, input int vs, input int d, input int ls,
                                input int fs, input int fc, input int pe);
        exp_t e;
        e.cyc = cyc; e.ep = ep; e.h = h; e.v = v; e.hs = hs; e.vs = vs;
        e.d = d; e.ls = ls; e.fs = fs; e.fc = fc; e.pe = pe;
        return e;
    endfunction

    task automatic compare(input string name, input exp_t g, input exp_t e);
        checks++;
        if (g.h != e.h || g.v != e.v || g.hs != e.hs || g.vs != e.vs || g.d != e.d ||
            g.ls != e.ls || g.fs != e.fs || g.fc != e.fc || g.pe != e.pe) begin
            errors++;
            $display("FAIL %s cyc=%0d ep=%0d got h=%0d v=%0d hs=%0d vs=%0d disp=%0d ls=%0d fs=%0d fc=%0d pe=%0d required h=%0d v=%0d hs=%0d vs=%0d disp=%0d ls=%0d fs=%0d fc=%0d pe=%0d",
                     name, e.cyc, e.ep, g.h, g.v, g.hs, g.vs, g.d, g.ls, g.fs, g.fc, g.pe,
                     e.h, e.v, e.hs, e.vs, e.d, e.ls, e.fs, e.fc, e.pe);
        end
    endtask

    task automatic check_count(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s got=%0d required=%0d", name, got, req);
        end
    endtask

    // Small-DUT monitor: pop the expectation that matches the current cycle/epoch
    always @(negedge clk) begin
        while (q_s.size() > 0 && (q_s[0].ep < epoch || (q_s[0].ep == epoch && q_s[0].cyc < act))) begin
            es = q_s.pop_front();
            checks++; errors++;
            $display("FAIL small_missed cyc=%0d ep=%0d never observed", es.cyc, es.ep);
        end
        if (q_s.size() > 0 && q_s[0].ep == epoch && q_s[0].cyc == act) begin
            es = q_s.pop_front();
            gs = mk(act, epoch, int'(s_hpos), int'(s_vpos), int'(s_hsync), int'(s_vsync),
                    int'(s_disp), int'(s_ls), int'(s_fs), int'(s_fc), int'(s_pix_en));
            compare("small", gs, es);
        end
        if (epoch == 0 && act > 0 && act <= 1152) begin
            ls_n += int'(s_ls);
            fs_n += int'(s_fs);
            pe_n += int'(s_pix_en);
        end
    end

    // Default-DUT monitor
    always @(negedge clk) begin
        while (q_d.size() > 0 && (q_d[0].ep < epoch || (q_d[0].ep == epoch && q_d[0].cyc < dact))) begin
            ed = q_d.pop_front();
            checks++; errors++;
            $display("FAIL default_missed cyc=%0d ep=%0d never observed", ed.cyc, ed.ep);
        end
        if (q_d.size() > 0 && q_d[0].ep == epoch && q_d[0].cyc == dact) begin
            ed = q_d.pop_front();
            gd = mk(dact, epoch, int'(d_hpos), int'(d_vpos), int'(d_hsync), int'(d_vsync),
                    int'(d_disp), int'(d_ls), int'(d_fs), int'(d_fc), int'(d_pix_en));
            compare("default", gd, ed);
        end
        if (epoch == 0 && dact >= 1 && dact <= 800) begin
            hs_low_n   += int'(!d_hsync);
            disp_low_n += int'(!d_disp);
        end
    end

    // Wait (bounded) until the small DUT's enabled-edge count reaches target
    task automatic wait_act(input int target);
        int n;
        n = 0;
        while (act != target && n < 5000) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (act != target) begin
            checks++; errors++;
            $display("FAIL wait_act timeout got=%0d required=%0d", act, target);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ena   = 1'b1;
        dena  = 1'b1;

        // Small raster: cyc = enabled edges, pixel m lands at cyc 3m
        q_s.push_back(mk(   0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        q_s.push_back(mk(   2, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1));
        q_s.push_back(mk(   3, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0));
        q_s.push_back(mk(  12, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0));
        q_s.push_back(mk(  15, 0, 5, 0, 1, 0, 0, 0, 0, 0, 0));
        q_s.push_back(mk(  18, 0, 6, 0, 1, 0, 0, 0, 0, 0, 0));
        q_s.push_back(mk(  21, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0));
        q_s.push_back(mk(  24, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0));
        q_s.push_back(mk(  25, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0));
        q_s.push_back(mk(  72, 0, 0, 3, 0, 0, 0, 1, 0, 0, 0));
        q_s.push_back(mk(  96, 0, 0, 4, 0, 1, 0, 1, 0, 0, 0));
        q_s.push_back(mk( 105, 0, 3, 4, 0, 1, 0, 0, 0, 0, 0));
        q_s.push_back(mk( 120, 0, 0, 5, 0, 0, 0, 1, 0, 0, 0));
        q_s.push_back(mk( 141, 0, 7, 5, 0, 0, 0, 0, 0, 0, 0));
        q_s.push_back(mk( 144, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0));
        q_s.push_back(mk( 145, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0));
        q_s.push_back(mk(1008, 0, 0, 0, 0, 0, 1, 1, 1, 7, 0));
        q_s.push_back(mk(1152, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0));
        for (int i = 0; i < 11; i++) q_s.push_back(mk(1174, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0));
        q_s.push_back(mk(1175, 0, 7, 0, 0, 0, 0, 0, 0, 0, 1));
        q_s.push_back(mk(1176, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0));
        q_s.push_back(mk(1350, 0, 2, 2, 0, 0, 1, 0, 0, 1, 0));
        q_s.push_back(mk(   0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        q_s.push_back(mk(   2, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1));
        q_s.push_back(mk(   3, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0));
        q_s.push_back(mk(  30, 1, 2, 1, 0, 0, 1, 0, 0, 0, 0));

        // Default raster: cyc = edges since reset, one pixel per edge
        q_d.push_back(mk(   0, 0,   0, 0, 1, 1, 1, 0, 0, 0, 0));
        q_d.push_back(mk(   1, 0,   1, 0, 1, 1, 1, 0, 0, 0, 1));
        q_d.push_back(mk( 639, 0, 639, 0, 1, 1, 1, 0, 0, 0, 1));
        q_d.push_back(mk( 640, 0, 640, 0, 1, 1, 0, 0, 0, 0, 1));
        q_d.push_back(mk( 655, 0, 655, 0, 1, 1, 0, 0, 0, 0, 1));
        q_d.push_back(mk( 656, 0, 656, 0, 0, 1, 0, 0, 0, 0, 1));
        q_d.push_back(mk( 751, 0, 751, 0, 0, 1, 0, 0, 0, 0, 1));
        q_d.push_back(mk( 752, 0, 752, 0, 1, 1, 0, 0, 0, 0, 1));
        q_d.push_back(mk( 799, 0, 799, 0, 1, 1, 0, 0, 0, 0, 1));
        q_d.push_back(mk( 800, 0,   0, 1, 1, 1, 1, 1, 0, 0, 1));
        q_d.push_back(mk( 801, 0,   1, 1, 1, 1, 1, 0, 0, 0, 1));
        q_d.push_back(mk(1360, 0, 560, 1, 1, 1, 1, 0, 0, 0, 1));
        q_d.push_back(mk(   0, 1,   0, 0, 1, 1, 1, 0, 0, 0, 0));
        q_d.push_back(mk(   1, 1,   1, 0, 1, 1, 1, 0, 0, 0, 1));
        q_d.push_back(mk(  30, 1,  30, 0, 1, 1, 1, 0, 0, 0, 1));

        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // Freeze at hpos=7 with div=1 for 10 clocks
        wait_act(1174);
        ena = 1'b0;
        repeat (10) @(posedge clk);
        #2 ena = 1'b1;

        // Reset mid-frame, then restart
        wait_act(1351);
        rst_n = 1'b0;
        epoch = 1;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        wait_act(30);
        repeat (3) @(posedge clk);
        #2;

        check_count("line_start_8_frames", ls_n, 48);
        check_count("frame_start_8_frames", fs_n, 8);
        check_count("pix_en_8_frames", pe_n, 384);
        check_count("hsync_low_pixels_line0", hs_low_n, 96);
        check_count("display_off_pixels_line0", disp_low_n, 160);
        check_count("small_queue_left", q_s.size(), 0);
        check_count("default_queue_left", q_d.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
